// File: rtl/td4_seg_scan_ctrl.sv
// rtl/td4_seg_scan_ctrl.sv - four-digit multiplexed 7-segment scan controller with shadow/active buffering
// Optional leading-zero blanking is enabled by defining TD4_SEG_LZB_EN.
module td4_seg_scan_ctrl #(
    parameter int PRESCALE  = 10000,
    parameter int BLANK_CYC = 16
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        EN_I,
    input  logic        LOAD_I,
    input  logic [15:0] DATA_I,
    input  logic [3:0]  DP_I,
    output logic [6:0]  SEG_O,
    output logic        DP_O,
    output logic [3:0]  DIG_OEN_O,
    output logic        UPD_O,
    output logic        FRAME_O
);

    localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_dig;
    logic          r_run;
    logic [15:0]   r_act_data;
    logic [3:0]    r_act_dp;
    logic [15:0]   r_sh_data;
    logic [3:0]    r_sh_dp;
    logic          r_pend;

    logic [CW-1:0] w_cnt_nxt;
    logic [1:0]    w_dig_nxt;
    logic          w_wrap;
    logic          w_start;
    logic          w_xfer;
    logic [15:0]   w_act_data_nxt;
    logic [3:0]    w_act_dp_nxt;
    logic [3:0]    w_nib;
    logic          w_blank;
    logic          w_lzb;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    // Outputs are registered from next-state values so they line up with cnt.
    always_comb begin
        w_wrap  = (r_cnt == CW'(PRESCALE - 1));
        w_start = EN_I && !r_run;
        w_xfer  = EN_I && r_pend && (w_start || (w_wrap && (r_dig == 2'd3)));
        if (!EN_I || w_start) begin
            w_cnt_nxt = '0;
            w_dig_nxt = 2'd0;
        end else if (w_wrap) begin
            w_cnt_nxt = '0;
            w_dig_nxt = r_dig + 2'd1;
        end else begin
            w_cnt_nxt = r_cnt + CW'(1);
            w_dig_nxt = r_dig;
        end
        w_act_data_nxt = r_act_data;
        w_act_dp_nxt   = r_act_dp;
        if (w_xfer) begin
            w_act_data_nxt = LOAD_I ? DATA_I : r_sh_data;
            w_act_dp_nxt   = LOAD_I ? DP_I   : r_sh_dp;
        end
        w_nib   = w_act_data_nxt[{w_dig_nxt, 2'b00} +: 4];
        w_blank = !EN_I || (w_cnt_nxt < CW'(BLANK_CYC));
    end

`ifdef TD4_SEG_LZB_EN
    always_comb begin
        case (w_dig_nxt)
            2'd3:    w_lzb = (w_act_data_nxt[15:12] == 4'h0);
            2'd2:    w_lzb = (w_act_data_nxt[15:8]  == 8'h00);
            2'd1:    w_lzb = (w_act_data_nxt[15:4]  == 12'h000);
            default: w_lzb = 1'b0;
        endcase
    end
`else
    assign w_lzb = 1'b0;
`endif

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_cnt      <= '0;
            r_dig      <= 2'd0;
            r_run      <= 1'b0;
            r_act_data <= 16'h0000;
            r_act_dp   <= 4'h0;
            r_sh_data  <= 16'h0000;
            r_sh_dp    <= 4'h0;
            r_pend     <= 1'b0;
            SEG_O      <= 7'h7F;
            DP_O       <= 1'b1;
            DIG_OEN_O  <= 4'hF;
            UPD_O      <= 1'b0;
            FRAME_O    <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_dig      <= w_dig_nxt;
            r_run      <= EN_I;
            r_act_data <= w_act_data_nxt;
            r_act_dp   <= w_act_dp_nxt;
            // A load coinciding with a transfer bypasses the shadow entirely.
            if (w_xfer) begin
                r_pend <= 1'b0;
            end else if (LOAD_I) begin
                r_sh_data <= DATA_I;
                r_sh_dp   <= DP_I;
                r_pend    <= 1'b1;
            end
            UPD_O   <= w_xfer;
            FRAME_O <= EN_I && (w_cnt_nxt == '0) && (w_dig_nxt == 2'd0);
            if (w_blank) begin
                SEG_O     <= 7'h7F;
                DP_O      <= 1'b1;
                DIG_OEN_O <= 4'hF;
            end else begin
                SEG_O     <= w_lzb ? 7'h7F : ~hex7(w_nib);
                DP_O      <= ~w_act_dp_nxt[w_dig_nxt];
                DIG_OEN_O <= ~(4'b0001 << w_dig_nxt);
            end
        end
    end

endmodule
